match_clock_ctrl: RTL and testbench

- Upstream stage of the match countdown timer.
- Converts the board clock into the single-cycle one_sec enable pulse that the countdown consumes.
- Gates the pulse with a match FSM: start, pause/resume from keyboard, automatic freeze after a goal, stop on game_over.
- Sits between the keyboard decoder / goal detector and the countdown timer; its status outputs drive HUD overlays.

---
 rtl/match_pkg.sv | 15 +
 rtl/tick_prescaler.sv | 34 +++
 rtl/match_clock_ctrl.sv | 149 ++++++++++++++
 tb/tb_match_clock_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// Shared match-clock types and constants, also imported by the HUD overlays.
package match_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUNNING,
    PAUSED,
    GOAL_HOLD,
    OVER
  } match_state_t;

  localparam int unsigned GOAL_HOLD_SEC_DEFAULT = 3;
  localparam int unsigned HOLD_W                = 4;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: counts while enabled, wraps at a runtime terminal count.
module tick_prescaler #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] terminal,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q, count_d;

  // >= rather than == so a terminal lowered below the count wraps on the next cycle
  always_comb begin
    wrap    = enable && !clear && (count_q >= terminal);
    count_d = count_q;
    if (clear || wrap) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/match_clock_ctrl.sv
// Match clock FSM: gates the one_sec tick with start/pause/goal-hold/over states.
// Optional turbo rate (turbo_key port) enabled by defining MATCH_CLOCK_TURBO_EN.
module match_clock_ctrl
  import match_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = 31_500_000,
  parameter int unsigned GOAL_HOLD_SEC = GOAL_HOLD_SEC_DEFAULT
`ifdef MATCH_CLOCK_TURBO_EN
  ,
  parameter int unsigned TURBO_DIV     = 10
`endif
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              start_key,
  input  logic              pause_key,
  input  logic              goal_scored,
  input  logic              game_over,
`ifdef MATCH_CLOCK_TURBO_EN
  input  logic              turbo_key,
`endif
  output logic              one_sec,
  output logic              running,
  output logic              paused,
  output logic              goal_hold,
  output logic              match_over,
  output logic [HOLD_W-1:0] hold_left
);

  localparam int unsigned CW = (CLK_FREQ_HZ > 2) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [CW-1:0] TC_NORMAL = CW'(CLK_FREQ_HZ - 1);
`ifdef MATCH_CLOCK_TURBO_EN
  localparam logic [CW-1:0] TC_TURBO  = CW'(CLK_FREQ_HZ / TURBO_DIV - 1);
`endif

  match_state_t      state_q, state_d;
  logic              start_dly_q, start_dly_d, pause_dly_q, pause_dly_d;
  logic              start_arm_q, start_arm_d, pause_arm_q, pause_arm_d;
  logic              one_sec_q, one_sec_d;
  logic              running_q, running_d, paused_q, paused_d;
  logic              goal_hold_q, goal_hold_d, match_over_q, match_over_d;
  logic [HOLD_W-1:0] hold_left_q, hold_left_d;

  logic              start_rise, pause_rise;
  logic              stay_running, tick_en, tick_clr, tick_wrap;
  logic [CW-1:0]     tick_tc;

  // The arm flags keep a key held across reset release from counting as a press
  // until it has been seen low once.
  always_comb begin
    start_dly_d  = start_key;
    pause_dly_d  = pause_key;
    start_arm_d  = start_arm_q | ~start_key;
    pause_arm_d  = pause_arm_q | ~pause_key;
    start_rise   = start_key & ~start_dly_q & start_arm_q;
    pause_rise   = pause_key & ~pause_dly_q & pause_arm_q;

    // Prescaler controls derived from inputs only, so they never depend on its wrap.
    stay_running = (state_q == RUNNING) && !game_over && !goal_scored && !pause_rise;
    tick_en      = stay_running || ((state_q == GOAL_HOLD) && !game_over);
    tick_clr     = game_over || (state_q == IDLE) || (state_q == OVER) ||
                   ((state_q == RUNNING) && goal_scored);
  end

`ifdef MATCH_CLOCK_TURBO_EN
  assign tick_tc = (turbo_key && (state_q == RUNNING)) ? TC_TURBO : TC_NORMAL;
`else
  assign tick_tc = TC_NORMAL;
`endif

  tick_prescaler #(
    .WIDTH (CW)
  ) u_prescaler (
    .clk      (clk),
    .resetN   (resetN),
    .enable   (tick_en),
    .clear    (tick_clr),
    .terminal (tick_tc),
    .wrap     (tick_wrap)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start_rise) state_d = RUNNING;
      RUNNING: begin
        if (goal_scored)     state_d = GOAL_HOLD;
        else if (pause_rise) state_d = PAUSED;
      end
      PAUSED:    if (pause_rise || start_rise) state_d = RUNNING;
      GOAL_HOLD: if (tick_wrap && (hold_left_q == HOLD_W'(1))) state_d = RUNNING;
      OVER:      state_d = OVER;
      default:   state_d = IDLE;
    endcase
    if (game_over) state_d = OVER;

    one_sec_d = stay_running && tick_wrap;

    hold_left_d = hold_left_q;
    if (state_d != GOAL_HOLD) begin
      hold_left_d = '0;
    end else if (state_q != GOAL_HOLD) begin
      hold_left_d = HOLD_W'(GOAL_HOLD_SEC);
    end else if (tick_wrap) begin
      hold_left_d = hold_left_q - 1'b1;
    end

    running_d    = (state_d == RUNNING);
    paused_d     = (state_d == PAUSED);
    goal_hold_d  = (state_d == GOAL_HOLD);
    match_over_d = (state_d == OVER);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      start_dly_q  <= 1'b0;
      pause_dly_q  <= 1'b0;
      start_arm_q  <= 1'b0;
      pause_arm_q  <= 1'b0;
      one_sec_q    <= 1'b0;
      running_q    <= 1'b0;
      paused_q     <= 1'b0;
      goal_hold_q  <= 1'b0;
      match_over_q <= 1'b0;
      hold_left_q  <= '0;
    end else begin
      state_q      <= state_d;
      start_dly_q  <= start_dly_d;
      pause_dly_q  <= pause_dly_d;
      start_arm_q  <= start_arm_d;
      pause_arm_q  <= pause_arm_d;
      one_sec_q    <= one_sec_d;
      running_q    <= running_d;
      paused_q     <= paused_d;
      goal_hold_q  <= goal_hold_d;
      match_over_q <= match_over_d;
      hold_left_q  <= hold_left_d;
    end
  end

  assign one_sec    = one_sec_q;
  assign running    = running_q;
  assign paused     = paused_q;
  assign goal_hold  = goal_hold_q;
  assign match_over = match_over_q;
  assign hold_left  = hold_left_q;

endmodule

// File: tb/tb_match_clock_ctrl.sv
// Directed bench for match_clock_ctrl at CLK_FREQ_HZ=10, GOAL_HOLD_SEC=3.
module tb_match_clock_ctrl;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       start_key = 1'b0;
  logic       pause_key = 1'b0;
  logic       goal_scored = 1'b0;
  logic       game_over = 1'b0;
`ifdef MATCH_CLOCK_TURBO_EN
  logic       turbo_key = 1'b0;
`endif
  logic       one_sec, running, paused, goal_hold, match_over;
  logic [3:0] hold_left;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  match_clock_ctrl #(
    .CLK_FREQ_HZ   (10),
    .GOAL_HOLD_SEC (3)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .start_key   (start_key),
    .pause_key   (pause_key),
    .goal_scored (goal_scored),
    .game_over   (game_over),
`ifdef MATCH_CLOCK_TURBO_EN
    .turbo_key   (turbo_key),
`endif
    .one_sec     (one_sec),
    .running     (running),
    .paused      (paused),
    .goal_hold   (goal_hold),
    .match_over  (match_over),
    .hold_left   (hold_left)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_one_sec"},    32'(one_sec),    0);
    chk({tag, "_running"},    32'(running),    0);
    chk({tag, "_paused"},     32'(paused),     0);
    chk({tag, "_goal_hold"},  32'(goal_hold),  0);
    chk({tag, "_match_over"}, 32'(match_over), 0);
    chk({tag, "_hold_left"},  32'(hold_left),  0);
  endtask

  int exp_hold;

  initial begin
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    resetN = 1'b1;
    repeat (2) @(negedge clk);

    // Start: entry on edge 1, pulses after edges 11, 21, 31
    start_key = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (k == 2) start_key = 1'b0;
      chk("start_one_sec", 32'(one_sec), 32'(k == 11 || k == 21 || k == 31));
      chk("start_running", 32'(running), 1);
    end

    // Prescaler is 4 here; pause for 20 cycles, resume, pulse 6 cycles later
    pause_key = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      chk("pause_paused", 32'(paused), 1);
      chk("pause_one_sec", 32'(one_sec), 0);
      if (j == 4)  pause_key = 1'b0;
      if (j == 19) pause_key = 1'b1;
    end
    for (int m = 0; m < 8; m++) begin
      @(negedge clk);
      if (m == 1) pause_key = 1'b0;
      chk("resume_one_sec", 32'(one_sec), 32'(m == 6));
      chk("resume_running", 32'(running), 1);
    end

    // Goal: 30 cycles of hold (3,2,1), a repeat goal at n=15 is ignored
    goal_scored = 1'b1;
    for (int n = 0; n < 42; n++) begin
      @(negedge clk);
      goal_scored = (n == 15);
      exp_hold = (n < 10) ? 3 : (n < 20) ? 2 : (n < 30) ? 1 : 0;
      chk("goal_goal_hold", 32'(goal_hold), 32'(n < 30));
      chk("goal_running", 32'(running), 32'(n >= 30));
      chk("goal_hold_left", 32'(hold_left), 32'(exp_hold));
      chk("goal_one_sec", 32'(one_sec), 32'(n == 40));
    end

    // goal_scored beats pause rise
    goal_scored = 1'b1;
    pause_key   = 1'b1;
    @(negedge clk);
    goal_scored = 1'b0;
    pause_key   = 1'b0;
    chk("sim_goal_hold", 32'(goal_hold), 1);
    chk("sim_paused", 32'(paused), 0);
    chk("sim_hold_left", 32'(hold_left), 3);
    repeat (11) @(negedge clk);
    chk("mid_hold_left", 32'(hold_left), 2);

    // Asynchronous reset in the middle of the hold
    resetN = 1'b0;
    #1;
    chk_all_zero("reset_mid_hold");
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);

    start_key = 1'b1;
    @(negedge clk);
    chk("restart_running", 32'(running), 1);
    start_key = 1'b0;
    repeat (3) @(negedge clk);

    // game_over beats goal_scored; OVER is sticky
    game_over   = 1'b1;
    goal_scored = 1'b1;
    @(negedge clk);
    goal_scored = 1'b0;
    chk("over_match_over", 32'(match_over), 1);
    chk("over_goal_hold", 32'(goal_hold), 0);
    chk("over_running", 32'(running), 0);
    chk("over_hold_left", 32'(hold_left), 0);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (i == 3) game_over = 1'b0;
      if (i == 5) start_key = 1'b1;
      if (i == 7) start_key = 1'b0;
      chk("over_sticky", 32'(match_over), 1);
      chk("over_one_sec", 32'(one_sec), 0);
    end

    // Start key held through reset release gives no start
    start_key = 1'b1;
    resetN    = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("keyheld_running", 32'(running), 0);
      chk("keyheld_match_over", 32'(match_over), 0);
    end
    start_key = 1'b0;
    @(negedge clk);
    start_key = 1'b1;
    @(negedge clk);
    chk("keyheld_restart", 32'(running), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
